fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage directly upstream of the decode stage (`control_unit`). It owns the program counter and issues sequential word-aligned requests to instruction memory through a valid/ready request port with in-order responses. Returned words are buffered in a small FIFO, and fetch redirects from branch/jump resolution are honoured. It presents one instruction per handshake to decode, with `opcode`/`func3`/`func7` pre-sliced.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- `DEPTH`, 4, instruction buffer entries; power of two, ≥2.

- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `imem_req_valid`  out  1  request address valid
- `imem_req_ready`  in  1  memory accepts request this cycle
- `imem_req_addr`  out  32  word-aligned fetch address
- `imem_rsp_valid`  in  1  response word valid; in order, one per accepted request, ≥1 cycle after acceptance
- `imem_rsp_data`  in  32  instruction word
- `redirect_valid`  in  1  one-cycle pulse: discard the in-flight stream, restart at `redirect_pc`
- `redirect_pc`  in  32  new fetch address; bits [1:0] ignored (forced 0)
- `id_valid`  out  1  buffer head valid toward decode
- `id_ready`  in  1  decode accepts head
- `id_pc`  out  32  PC of head instruction
- `id_instr`  out  32  head instruction word
- `id_opcode`  out  7  `id_instr[6:0]`
- `id_func3`  out  3  `id_instr[14:12]`
- `id_func7`  out  7  `id_instr[31:25]`

## Operation
- State: `fetch_pc`; `outstanding` counter (accepted, unanswered requests); `discard` counter (responses to drop); FIFO of {pc, instr}, with `occ` = entry count.
- FSM states:
  - RESET: held while `rst_n`=0; goes to RUN on the first clock edge after release.
  - RUN: requests are issued.
  - DRAIN: no requests; responses are dropped. Returns to RUN when `discard` reaches 0, including the same cycle a response decrements it to 0.
- Request rule (RUN only): `imem_req_valid` = (`outstanding` + `occ` − (`id_valid`&`id_ready`)) < `DEPTH`. The credit check guarantees FIFO space for every response.
- Request acceptance (`imem_req_valid`&`imem_req_ready`): `outstanding`+1 and `fetch_pc` += 4, modulo 2^32 (0xFFFF_FFFC wraps to 0). `imem_req_addr` = `fetch_pc` and is held stable while valid and not ready.
- Response in RUN: push {pc of that request, data} and decrement `outstanding`. Pushed pc is tracked by a `rsp_pc` register that advances by 4 per response.
- Response in DRAIN: drop the word and decrement both `outstanding` and `discard`.
- Decode handshake: pop head when `id_valid`&`id_ready`. `id_valid` = `occ`≠0 and no redirect this cycle.
- Redirect (any state), applied on the next edge:
  - FIFO flushed (`occ`=0); a same-cycle pop is irrelevant.
  - `fetch_pc` and `rsp_pc` ← {`redirect_pc`[31:2],2'b00}.
  - `discard` ← `outstanding` + (request accepted this cycle) − (response this cycle). A same-cycle response is dropped.
  - Next state: DRAIN if the new `discard`≠0, else RUN.
  - A redirect during DRAIN recomputes `discard` by the same formula.
- Simultaneous push and pop are legal at any occupancy, including full.
- `imem_rsp_valid` with `outstanding`=0 is a protocol error: the word is ignored and state is unchanged.

## Timing
- Reset values:
  - `imem_req_valid`=0, `imem_req_addr`=`RESET_PC`
  - `id_valid`=0, `id_pc`=0, `id_instr`=0 (hence `id_opcode`/`id_func3`/`id_func7`=0)
  - counters 0, FSM RESET
- The first request is asserted in the first cycle after the first rising edge with `rst_n`=1.
- Request accepted at cycle N, response at N+L (L≥1): entry pushed at edge ending N+L, `id_valid` high in N+L+1.
- Throughput: 1 instr/cycle sustained at L=1 with `DEPTH`≥2 and `id_ready` held high.
- Redirect pulse at cycle R: cycle R+1 requests `redirect_pc` (if no discards pending) and `id_valid`=0 in R+1.
- Reset asserted mid-operation clears all state immediately (asynchronous). Responses to requests accepted before reset are not tracked.

## Test plan
- Streaming: reset, `imem_req_ready`=1, L=1, `id_ready`=1 → addresses 0,4,8,…; first `id_valid` in cycle 3 with `id_pc`=0; then one instruction/cycle; `id_opcode` = `imem_rsp_data`[6:0].
- Back-pressure: `id_ready`=0 for 10 cycles → exactly `DEPTH` entries buffered, `imem_req_valid` drops to 0; release → PCs 0..4·(DEPTH−1) delivered in order, no loss or duplicate.
- Redirect with in-flight requests: L=3, pulse `redirect_pc`=0x100 with `outstanding`=3 → 3 responses dropped, no request issued during DRAIN, next delivered `id_pc`=0x100.
- Corner redirect: pulse in the same cycle as a request accept, a response and a pop, `redirect_pc`=0x203 → old words dropped, `id_pc`=0x200.
- Wrap: `redirect_pc`=0xFFFF_FFF8 → requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Async reset mid-stream: drop `rst_n` between edges → `imem_req_valid`/`id_valid` go 0 immediately; after release, fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word-aligned imem requests with credit-based
// flow control, buffers responses in a small FIFO and honours redirects from branch resolution.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [6:0]  id_opcode,
  output logic [2:0]  id_func3,
  output logic [6:0]  id_func7
);
  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = $clog2(DEPTH) + 1;
  localparam int unsigned CW1 = CW + 1;

  typedef enum logic [1:0] {S_RESET, S_RUN, S_DRAIN} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   pc_mem_q [DEPTH];
  logic [31:0]   pc_mem_d [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   instr_mem_d [DEPTH];

  logic          acc, rsp, push, pop;
  logic [CW1-1:0] credit;
  logic [31:0]   redirect_al;
  logic [31:0]   head_instr;

  assign redirect_al = {redirect_pc[31:2], 2'b00};

  // Output / handshake decode. The credit counts the popped slot as free so a full
  // buffer being drained this cycle can still request.
  always_comb begin
    head_instr     = instr_mem_q[rd_ptr_q];
    id_valid       = (occ_q != '0) && !redirect_valid;
    pop            = id_valid && id_ready;
    credit         = {1'b0, outstanding_q} + {1'b0, occ_q} - CW1'(pop);
    imem_req_valid = (state_q == S_RUN) && (credit < CW1'(DEPTH));
    imem_req_addr  = fetch_pc_q;
    acc            = imem_req_valid && imem_req_ready;
    rsp            = imem_rsp_valid && (outstanding_q != '0);
    push           = rsp && (state_q == S_RUN) && !redirect_valid;
    id_pc          = pc_mem_q[rd_ptr_q];
    id_instr       = head_instr;
    id_opcode      = head_instr[6:0];
    id_func3       = head_instr[14:12];
    id_func7       = head_instr[31:25];
  end

  always_comb begin
    outstanding_d = outstanding_q + CW'(acc) - CW'(rsp);
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    rd_ptr_d      = rd_ptr_q + PW'(pop);
    wr_ptr_d      = wr_ptr_q + PW'(push);
    occ_d         = occ_q + CW'(push) - CW'(pop);
    pc_mem_d      = pc_mem_q;
    instr_mem_d   = instr_mem_q;
    if (acc) fetch_pc_d = fetch_pc_q + 32'd4;
    if (push) begin
      rsp_pc_d              = rsp_pc_q + 32'd4;
      pc_mem_d[wr_ptr_q]    = rsp_pc_q;
      instr_mem_d[wr_ptr_q] = imem_rsp_data;
    end
    if (redirect_valid) begin
      fetch_pc_d = redirect_al;
      rsp_pc_d   = redirect_al;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      occ_d      = '0;
    end
  end

  // Everything still outstanding after this edge belongs to the discarded stream.
  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    case (state_q)
      S_RESET: state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      S_DRAIN: begin
        if (rsp) begin
          discard_d = discard_q - CW'(1);
          if (discard_d == '0) state_d = S_RUN;
        end
      end
      default: state_d = S_RESET;
    endcase
    if (redirect_valid) begin
      discard_d = outstanding_d;
      state_d   = (outstanding_d != '0) ? S_DRAIN : S_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_RESET;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      occ_q         <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      occ_q         <= occ_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      pc_mem_q      <= pc_mem_d;
      instr_mem_q   <= instr_mem_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a memory model answers requests in order with random
// latency, and a queue-based reference of the delivered stream checks every cycle.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_pc, id_instr;
  logic [6:0]  id_opcode, id_func7;
  logic [2:0]  id_func3;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr),
    .id_opcode(id_opcode), .id_func3(id_func3), .id_func7(id_func7)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;

  req_t        infl[$];
  ent_t        fifo[$];
  logic [31:0] fetch_exp;
  int          epoch, cyc, n_vec, n_err;
  bit          running;

  int p_rdy, p_idr, p_rsp, p_redir, lat_min, lat_max;
  bit force_redir;
  logic [31:0] force_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F17;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    bit   old_pending, exp_idv, pop, exp_rv, acc, rsp_hit;
    req_t r;
    ent_t e;
    int   in_use;
    @(negedge clk);
    imem_req_ready = ($urandom_range(99) < p_rdy);
    id_ready       = ($urandom_range(99) < p_idr);
    redirect_valid = running && (force_redir || ($urandom_range(99) < p_redir));
    redirect_pc    = force_redir ? force_pc : $urandom;
    imem_rsp_data  = $urandom;
    imem_rsp_valid = 1'b0;
    if (infl.size() != 0) begin
      if (infl[0].due <= cyc && $urandom_range(99) < p_rsp) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(infl[0].addr);
      end
    end else if (running && $urandom_range(99) < 2) begin
      imem_rsp_valid = 1'b1;  // stray response, must be ignored
    end
    #1;
    old_pending = 1'b0;
    foreach (infl[i]) if (infl[i].epoch != epoch) old_pending = 1'b1;
    exp_idv = (fifo.size() != 0) && !redirect_valid;
    pop     = exp_idv && id_ready;
    in_use  = infl.size() + fifo.size() - (pop ? 1 : 0);
    exp_rv  = running && !old_pending && (in_use < DEPTH);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    chk("req_addr", imem_req_addr, fetch_exp);
    chk("id_valid", 32'(id_valid), 32'(exp_idv));
    if (exp_idv) begin
      e = fifo[0];
      chk("id_pc", id_pc, e.pc);
      chk("id_instr", id_instr, e.ins);
      chk("id_opcode", 32'(id_opcode), 32'(e.ins[6:0]));
      chk("id_func3", 32'(id_func3), 32'(e.ins[14:12]));
      chk("id_func7", 32'(id_func7), 32'(e.ins[31:25]));
    end
    acc     = exp_rv && imem_req_ready;
    rsp_hit = imem_rsp_valid && (infl.size() != 0);
    @(posedge clk);
    cyc++;
    if (rsp_hit) r = infl.pop_front();
    if (pop) void'(fifo.pop_front());
    if (rsp_hit && !redirect_valid && r.epoch == epoch) begin
      e.pc  = r.addr;
      e.ins = mem_word(r.addr);
      fifo.push_back(e);
    end
    if (acc) begin
      r.addr  = fetch_exp;
      r.epoch = epoch;
      r.due   = cyc - 1 + $urandom_range(lat_max, lat_min);
      infl.push_back(r);
      fetch_exp = fetch_exp + 32'd4;
    end
    if (redirect_valid) begin
      fifo.delete();
      epoch++;
      fetch_exp = {redirect_pc[31:2], 2'b00};
    end
    running = 1'b1;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    force_redir = 1'b1;
    force_pc    = pc;
    step();
    force_redir = 1'b0;
  endtask

  task automatic model_reset();
    infl.delete();
    fifo.delete();
    fetch_exp = RESET_PC;
    running   = 1'b0;
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n          = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    chk("rst_id_pc", id_pc, 32'd0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic set_knobs(input int rdy, input int idr, input int rsp, input int rdr,
                           input int lmin, input int lmax);
    p_rdy = rdy; p_idr = idr; p_rsp = rsp; p_redir = rdr; lat_min = lmin; lat_max = lmax;
  endtask

  initial begin
    rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    n_vec = 0; n_err = 0; cyc = 0; epoch = 0; force_redir = 1'b0; force_pc = '0;
    model_reset();
    set_knobs(100, 100, 100, 0, 1, 1);
    #2;
    chk("reset_req_valid", 32'(imem_req_valid), 32'd0);
    chk("reset_req_addr", imem_req_addr, RESET_PC);
    chk("reset_id_valid", 32'(id_valid), 32'd0);
    chk("reset_id_pc", id_pc, 32'd0);
    chk("reset_id_instr", id_instr, 32'd0);
    chk("reset_id_fields", {15'd0, id_func7, id_func3, id_opcode}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    repeat (20) step();
    p_idr = 0;
    repeat (10) step();
    p_idr = 100;
    repeat (10) step();

    set_knobs(100, 100, 100, 0, 3, 3);
    repeat (10) step();
    redirect_to(32'h0000_0100);
    repeat (15) step();

    set_knobs(100, 100, 100, 0, 1, 1);
    repeat (10) step();
    redirect_to(32'h0000_0203);
    repeat (10) step();
    redirect_to(32'hFFFF_FFF8);
    repeat (10) step();

    async_reset();
    repeat (15) step();

    for (int blk = 0; blk < 16; blk++) begin
      set_knobs($urandom_range(100, 30), $urandom_range(100, 20), $urandom_range(100, 40),
                $urandom_range(5, 0), 1, $urandom_range(4, 1));
      repeat (200) step();
      if (blk == 7) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
